// File: rtl/round_robin_fetcher.sv
// round_robin_fetcher: per-warp fetch controller.
// Holds pc / active mask / state for every warp and issues one instruction-
// cache request per handshake. Warps are granted round-robin among READY
// warps; an issued warp waits for decode to return its next pc (or a stop).
// New warps are allocated through the init interface (lowest IDLE index).

module round_robin_fetcher #(
  parameter int NumWarps  = 8,
  parameter int WarpWidth = 32,
  parameter int PcWidth   = 32,
  parameter int WidWidth  = $clog2(NumWarps)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // warp start interface
  input  logic                 init_valid_i,
  output logic                 init_ready_o,
  input  logic [PcWidth-1:0]   init_pc_i,
  input  logic [WarpWidth-1:0] init_act_mask_i,
  output logic [WidWidth-1:0]  init_warp_id_o,
  // instruction cache request interface
  input  logic                 ic_ready_i,
  output logic                 fe_valid_o,
  output logic [PcWidth-1:0]   fe_pc_o,
  output logic [WarpWidth-1:0] fe_act_mask_o,
  output logic [WidWidth-1:0]  fe_warp_id_o,
  // decode feedback
  input  logic                 dec_valid_i,
  input  logic [WidWidth-1:0]  dec_warp_id_i,
  input  logic [PcWidth-1:0]   dec_next_pc_i,
  input  logic [WarpWidth-1:0] dec_act_mask_i,
  input  logic                 dec_stop_i,
  // status
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    WARP_IDLE    = 2'd0,
    WARP_READY   = 2'd1,
    WARP_WAITING = 2'd2
  } warp_state_e;

  // Per-warp architectural state.
  warp_state_e          state_q [NumWarps];
  warp_state_e          state_d [NumWarps];
  logic [PcWidth-1:0]   pc_q    [NumWarps];
  logic [PcWidth-1:0]   pc_d    [NumWarps];
  logic [WarpWidth-1:0] mask_q  [NumWarps];
  logic [WarpWidth-1:0] mask_d  [NumWarps];

  // Arbitration state: round-robin pointer and the held (locked) selection.
  logic [WidWidth-1:0]  rr_q, rr_d;
  logic                 lock_q, lock_d;
  logic [WidWidth-1:0]  lock_id_q, lock_id_d;

  // Decoded status vectors.
  logic [NumWarps-1:0]  idle_vec;
  logic [NumWarps-1:0]  ready_vec;
  logic [NumWarps-1:0]  ready_rot;

  // Allocation and arbitration results.
  logic                 alloc_found;
  logic [WidWidth-1:0]  alloc_id;
  logic                 cand_found;
  logic [WidWidth-1:0]  cand_offs;
  logic [WidWidth:0]    cand_sum;
  logic [WidWidth-1:0]  cand_id;
  logic [WidWidth-1:0]  sel_id;
  logic                 fe_valid;

  // Handshake / event strobes.
  logic                 init_hs;
  logic                 fetch_hs;
  logic                 dec_hit;

  // Decode per-warp state into IDLE / READY bit vectors.
  always_comb begin
    for (int w = 0; w < NumWarps; w++) begin
      idle_vec[w]  = (state_q[w] == WARP_IDLE);
      ready_vec[w] = (state_q[w] == WARP_READY);
    end
  end

  // Lowest-index IDLE warp: the slot the next init handshake fills.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves a variable unassigned would infer a latch.
    alloc_found = 1'b0;
    alloc_id    = '0;
    for (int w = 0; w < NumWarps; w++) begin
      if (idle_vec[w] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_id    = WidWidth'(w);
      end
    end
  end

  // Round-robin candidate: rotate READY bits so the pointer sits at bit 0,
  // take the first set bit, then map the offset back to a warp index.
  always_comb begin
    ready_rot  = NumWarps'({ready_vec, ready_vec} >> rr_q);
    cand_found = 1'b0;
    cand_offs  = '0;
    for (int i = 0; i < NumWarps; i++) begin
      if (ready_rot[i] && !cand_found) begin
        cand_found = 1'b1;
        cand_offs  = WidWidth'(i);
      end
    end
    cand_sum = {1'b0, rr_q} + {1'b0, cand_offs};
    if (cand_sum >= (WidWidth+1)'(NumWarps)) begin
      cand_sum = cand_sum - (WidWidth+1)'(NumWarps);
    end
    cand_id = cand_sum[WidWidth-1:0];
  end

  // A stalled request keeps its warp: the locked id overrides the scan so
  // newly READY warps cannot change the request while ic_ready_i is low.
  assign sel_id   = lock_q ? lock_id_q : cand_id;
  assign fe_valid = cand_found | lock_q;

  assign init_hs  = init_valid_i & alloc_found;
  assign fetch_hs = fe_valid & ic_ready_i;
  // Feedback only counts for a warp that actually has a request in flight.
  assign dec_hit  = dec_valid_i & (state_q[dec_warp_id_i] == WARP_WAITING);

  // Outputs: request data straight from the selected warp's registers.
  assign fe_valid_o     = fe_valid;
  assign fe_warp_id_o   = fe_valid ? sel_id         : '0;
  assign fe_pc_o        = fe_valid ? pc_q[sel_id]   : '0;
  assign fe_act_mask_o  = fe_valid ? mask_q[sel_id] : '0;
  assign init_ready_o   = alloc_found;
  assign init_warp_id_o = alloc_id;
  assign busy_o         = ~(&idle_vec);

  // Next pointer and lock: advance past the granted warp, hold on stall.
  always_comb begin
    rr_d      = rr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (fetch_hs) begin
      rr_d   = (sel_id == WidWidth'(NumWarps - 1)) ? '0 : sel_id + WidWidth'(1);
      lock_d = 1'b0;
    end else if (fe_valid) begin
      lock_d    = 1'b1;
      lock_id_d = sel_id;
    end
  end

  // Per-warp next state. Init targets an IDLE warp, fetch a READY one and
  // decode a WAITING one, so the three updates never collide.
  always_comb begin
    for (int w = 0; w < NumWarps; w++) begin
      state_d[w] = state_q[w];
      pc_d[w]    = pc_q[w];
      mask_d[w]  = mask_q[w];
    end
    if (init_hs) begin
      state_d[alloc_id] = WARP_READY;
      pc_d[alloc_id]    = init_pc_i;
      mask_d[alloc_id]  = init_act_mask_i;
    end
    if (fetch_hs) begin
      state_d[sel_id] = WARP_WAITING;
    end
    if (dec_hit) begin
      if (dec_stop_i) begin
        // pc / mask of a freed warp are left as-is; the next init overwrites them.
        state_d[dec_warp_id_i] = WARP_IDLE;
      end else begin
        state_d[dec_warp_id_i] = WARP_READY;
        pc_d[dec_warp_id_i]    = dec_next_pc_i;
        mask_d[dec_warp_id_i]  = dec_act_mask_i;
      end
    end
  end

  // Per-warp state, pc and mask registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the pc / mask arrays are reset too, so the request data and a
      // freshly reset warp never expose uninitialised contents.
      for (int w = 0; w < NumWarps; w++) begin
        state_q[w] <= WARP_IDLE;
        pc_q[w]    <= '0;
        mask_q[w]  <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge value of its next-state logic.
      for (int w = 0; w < NumWarps; w++) begin
        state_q[w] <= state_d[w];
        pc_q[w]    <= pc_d[w];
        mask_q[w]  <= mask_d[w];
      end
    end
  end

  // Round-robin pointer and lock registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

endmodule

// File: tb/tb_round_robin_fetcher.sv
// Directed bench for round_robin_fetcher with a fetch scoreboard: each
// expected request is queued when the stimulus that causes it is driven,
// and popped/compared whenever the cache interface handshakes.

module tb_round_robin_fetcher;

  localparam int NW = 8;
  localparam int WW = 32;
  localparam int PW = 32;
  localparam int IW = $clog2(NW);

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          init_valid_i;
  logic          init_ready_o;
  logic [PW-1:0] init_pc_i;
  logic [WW-1:0] init_act_mask_i;
  logic [IW-1:0] init_warp_id_o;
  logic          ic_ready_i;
  logic          fe_valid_o;
  logic [PW-1:0] fe_pc_o;
  logic [WW-1:0] fe_act_mask_o;
  logic [IW-1:0] fe_warp_id_o;
  logic          dec_valid_i;
  logic [IW-1:0] dec_warp_id_i;
  logic [PW-1:0] dec_next_pc_i;
  logic [WW-1:0] dec_act_mask_i;
  logic          dec_stop_i;
  logic          busy_o;

  round_robin_fetcher #(
    .NumWarps (NW),
    .WarpWidth(WW),
    .PcWidth  (PW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .init_valid_i   (init_valid_i),
    .init_ready_o   (init_ready_o),
    .init_pc_i      (init_pc_i),
    .init_act_mask_i(init_act_mask_i),
    .init_warp_id_o (init_warp_id_o),
    .ic_ready_i     (ic_ready_i),
    .fe_valid_o     (fe_valid_o),
    .fe_pc_o        (fe_pc_o),
    .fe_act_mask_o  (fe_act_mask_o),
    .fe_warp_id_o   (fe_warp_id_o),
    .dec_valid_i    (dec_valid_i),
    .dec_warp_id_i  (dec_warp_id_i),
    .dec_next_pc_i  (dec_next_pc_i),
    .dec_act_mask_i (dec_act_mask_i),
    .dec_stop_i     (dec_stop_i),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [IW-1:0] wid;
    logic [PW-1:0] pc;
    logic [WW-1:0] mask;
  } fetch_t;

  fetch_t exp_q[$];
  int     vectors     = 0;
  int     miscompares = 0;

  // Last handshake seen, used only to steer decode echo stimulus.
  logic          hs_flag = 1'b0;
  logic [IW-1:0] hs_wid  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int wid, input logic [PW-1:0] pc, input logic [WW-1:0] mask);
    fetch_t e;
    e.wid  = IW'(wid);
    e.pc   = pc;
    e.mask = mask;
    exp_q.push_back(e);
  endtask

  // Scoreboard: compare every cache handshake against the next expected fetch.
  always @(negedge clk_i) begin
    hs_flag = fe_valid_o && ic_ready_i;
    hs_wid  = fe_warp_id_o;
    if (rst_ni && fe_valid_o && ic_ready_i) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL fetch_extra: observed warp %0d pc 0x%0h, expected no fetch",
               fe_warp_id_o, fe_pc_o);
      end
      if (exp_q.size() != 0) begin
        fetch_t e;
        e = exp_q.pop_front();
        check("fetch_wid",  64'(fe_warp_id_o),  64'(e.wid));
        check("fetch_pc",   64'(fe_pc_o),       64'(e.pc));
        check("fetch_mask", 64'(fe_act_mask_o), 64'(e.mask));
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_fe_valid"},   64'(fe_valid_o),     64'd0);
    check({tag, "_init_ready"}, 64'(init_ready_o),   64'd1);
    check({tag, "_init_wid"},   64'(init_warp_id_o), 64'd0);
    check({tag, "_busy"},       64'(busy_o),         64'd0);
    check({tag, "_fe_pc"},      64'(fe_pc_o),        64'd0);
    check({tag, "_fe_mask"},    64'(fe_act_mask_o),  64'd0);
    check({tag, "_fe_wid"},     64'(fe_warp_id_o),   64'd0);
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    #2;
    check_idle_outputs("reset");
    cyc();
    rst_ni = 1'b1;
  endtask

  task automatic do_init(input int exp_id, input logic [PW-1:0] pc,
                         input logic [WW-1:0] mask, input bit push);
    check("init_ready", 64'(init_ready_o),   64'd1);
    check("init_wid",   64'(init_warp_id_o), 64'(exp_id));
    init_valid_i    = 1'b1;
    init_pc_i       = pc;
    init_act_mask_i = mask;
    if (push) push_exp(exp_id, pc, mask);
    cyc();
    init_valid_i = 1'b0;
  endtask

  task automatic do_dec(input int wid, input logic [PW-1:0] pc, input logic [WW-1:0] mask,
                        input bit stop, input bit push);
    dec_valid_i    = 1'b1;
    dec_warp_id_i  = IW'(wid);
    dec_next_pc_i  = pc;
    dec_act_mask_i = mask;
    dec_stop_i     = stop;
    if (push) push_exp(wid, pc, mask);
    cyc();
    dec_valid_i = 1'b0;
    dec_stop_i  = 1'b0;
  endtask

  logic [PW-1:0] mpc   [NW];
  logic [WW-1:0] mmask [NW];
  int            visits[NW];

  initial begin
    init_valid_i    = 1'b0;
    init_pc_i       = '0;
    init_act_mask_i = '0;
    ic_ready_i      = 1'b0;
    dec_valid_i     = 1'b0;
    dec_warp_id_i   = '0;
    dec_next_pc_i   = '0;
    dec_act_mask_i  = '0;
    dec_stop_i      = 1'b0;

    // Reset state.
    apply_reset();
    check_idle_outputs("post_reset");

    // Single warp: init, issue with zero latency, decode next pc, stop.
    ic_ready_i = 1'b1;
    do_init(0, 32'h10, 32'hFFFF_FFFF, 1'b1);
    check("s1_fe_valid", 64'(fe_valid_o),   64'd1);
    check("s1_fe_wid",   64'(fe_warp_id_o), 64'd0);
    check("s1_fe_pc",    64'(fe_pc_o),      64'h10);
    cyc();
    check("s1_after_hs_valid", 64'(fe_valid_o), 64'd0);
    check("s1_after_hs_busy",  64'(busy_o),     64'd1);
    do_dec(0, 32'h11, 32'hFFFF_FFFF, 1'b0, 1'b1);
    check("s1_dec_valid", 64'(fe_valid_o), 64'd1);
    check("s1_dec_pc",    64'(fe_pc_o),    64'h11);
    cyc();
    do_dec(0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("s1_stop_busy", 64'(busy_o), 64'd0);

    // Three warps with decode echoing pc+1: grants 0,1,2,0,1,2 then stop.
    for (int c = 0; c < 10; c++) begin
      init_valid_i = (c < 3);
      if (c < 3) begin
        check("s3_init_wid", 64'(init_warp_id_o), 64'(c));
        mpc[c]          = PW'(c) * 32'h100;
        mmask[c]        = 32'hA5A5_0000 | WW'(c);
        visits[c]       = 0;
        init_pc_i       = mpc[c];
        init_act_mask_i = mmask[c];
        push_exp(c, mpc[c], mmask[c]);
      end
      dec_valid_i = hs_flag;
      dec_stop_i  = 1'b0;
      if (hs_flag) begin
        int w;
        w = int'(hs_wid);
        visits[w]++;
        dec_warp_id_i = hs_wid;
        if (visits[w] >= 2) begin
          dec_stop_i = 1'b1;
        end else begin
          mpc[w]         = mpc[w] + 32'd1;
          mmask[w]       = mmask[w] ^ 32'h0000_FFFF;
          dec_next_pc_i  = mpc[w];
          dec_act_mask_i = mmask[w];
          push_exp(w, mpc[w], mmask[w]);
        end
      end
      cyc();
    end
    init_valid_i = 1'b0;
    dec_valid_i  = 1'b0;
    dec_stop_i   = 1'b0;
    check("s3_drain", 64'(exp_q.size()), 64'd0);
    check("s3_busy",  64'(busy_o),       64'd0);

    // Stall lock: warp 0 selected with pointer at 2; warps 3 and 1 become
    // READY during a 4-cycle stall and must not preempt it.
    apply_reset();
    ic_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_init(i, 32'h1000 * PW'(i + 1), 32'hFFFF_0000 | WW'(i), 1'b1);
    end
    cyc();
    cyc();
    do_dec(2, 32'h3001, 32'h0F0F_0F02, 1'b0, 1'b1);
    do_dec(1, 32'h2001, 32'h0F0F_0F01, 1'b0, 1'b1);
    cyc();
    ic_ready_i = 1'b0;
    do_dec(0, 32'h1001, 32'h0F0F_0F00, 1'b0, 1'b0);
    check("lock_c0_valid", 64'(fe_valid_o),   64'd1);
    check("lock_c0_wid",   64'(fe_warp_id_o), 64'd0);
    check("lock_c0_pc",    64'(fe_pc_o),      64'h1001);
    do_dec(3, 32'h4001, 32'h0F0F_0F03, 1'b0, 1'b0);
    check("lock_c1_wid",   64'(fe_warp_id_o), 64'd0);
    check("lock_c1_pc",    64'(fe_pc_o),      64'h1001);
    do_dec(1, 32'h2002, 32'h0F0F_0F11, 1'b0, 1'b0);
    check("lock_c2_wid",   64'(fe_warp_id_o), 64'd0);
    check("lock_c2_pc",    64'(fe_pc_o),      64'h1001);
    cyc();
    check("lock_c3_wid",   64'(fe_warp_id_o),  64'd0);
    check("lock_c3_pc",    64'(fe_pc_o),       64'h1001);
    check("lock_c3_mask",  64'(fe_act_mask_o), 64'h0F0F_0F00);
    push_exp(0, 32'h1001, 32'h0F0F_0F00);
    push_exp(1, 32'h2002, 32'h0F0F_0F11);
    push_exp(3, 32'h4001, 32'h0F0F_0F03);
    ic_ready_i = 1'b1;
    cyc();
    cyc();
    cyc();
    check("lock_drain", 64'(exp_q.size()), 64'd0);

    // Ignored feedback: decode to a READY warp and to an IDLE warp.
    ic_ready_i = 1'b0;
    do_dec(0, 32'h1002, 32'h1234_5678, 1'b0, 1'b1);
    check("ign_pre_pc", 64'(fe_pc_o), 64'h1002);
    do_dec(0, 32'hDEAD, 32'hDEAD_DEAD, 1'b0, 1'b0);
    do_dec(5, 32'hBEEF, 32'hBEEF_BEEF, 1'b0, 1'b0);
    check("ign_wid",      64'(fe_warp_id_o),   64'd0);
    check("ign_pc",       64'(fe_pc_o),        64'h1002);
    check("ign_mask",     64'(fe_act_mask_o),  64'h1234_5678);
    check("ign_init_wid", 64'(init_warp_id_o), 64'd4);
    ic_ready_i = 1'b1;
    cyc();
    check("ign_no_extra", 64'(fe_valid_o), 64'd0);
    do_dec(0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("stop_init_ready", 64'(init_ready_o),   64'd1);
    check("stop_init_wid",   64'(init_warp_id_o), 64'd0);
    check("ign_drain",       64'(exp_q.size()),   64'd0);

    // Reset while warps are still WAITING clears everything at once.
    apply_reset();

    // Fill all warps, then try to allocate with no IDLE warp.
    ic_ready_i = 1'b1;
    for (int i = 0; i < NW; i++) begin
      do_init(i, 32'h8000 + PW'(i) * 32'h10, 32'h00FF_0000 | WW'(i), 1'b1);
    end
    check("full_init_ready", 64'(init_ready_o), 64'd0);
    init_valid_i    = 1'b1;
    init_pc_i       = 32'hBAD;
    init_act_mask_i = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("full_hold_ready", 64'(init_ready_o), 64'd0);
      check("full_hold_busy",  64'(busy_o),       64'd1);
    end
    init_valid_i = 1'b0;
    check("full_drain", 64'(exp_q.size()), 64'd0);
    do_dec(6, 32'h0, 32'h0, 1'b1, 1'b0);
    check("free6_ready", 64'(init_ready_o),   64'd1);
    check("free6_wid",   64'(init_warp_id_o), 64'd6);
    do_init(6, 32'h9000, 32'h0000_0066, 1'b1);
    check("realloc_init_ready", 64'(init_ready_o), 64'd0);
    cyc();
    cyc();
    check("realloc_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/round_robin_fetcher.md
Name: round_robin_fetcher

Overview:
- Per-warp fetch controller that drives the fetcher→instruction-cache request interface (fe_valid/ic_ready, pc, act_mask, warp_id).
- Holds PC, active mask and state for each warp, arbitrates round-robin among warps that may fetch, and issues one request per handshake.
- After issue, a warp blocks until decode returns its next PC, or a stop that frees it.
- Warps are allocated through a start interface that picks the lowest free warp.

Parameters:
- NumWarps, 8, warps per compute unit (≥2).
- WarpWidth, 32, threads per warp, active-mask width.
- PcWidth, 32, program counter width.
- WidWidth, $clog2(NumWarps), dependent, do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- init_valid_i  in  1  request to start a new warp.
- init_ready_o  out  1  at least one warp is IDLE.
- init_pc_i  in  PcWidth  start PC.
- init_act_mask_i  in  WarpWidth  start active mask.
- init_warp_id_o  out  WidWidth  lowest IDLE warp index; the index allocated on handshake.
- ic_ready_i  in  1  instruction cache accepts a request.
- fe_valid_o  out  1  fetch request valid.
- fe_pc_o  out  PcWidth  PC of the selected warp.
- fe_act_mask_o  out  WarpWidth  active mask of the selected warp.
- fe_warp_id_o  out  WidWidth  selected warp.
- dec_valid_i  in  1  decode reports a decoded instruction.
- dec_warp_id_i  in  WidWidth  warp of the report.
- dec_next_pc_i  in  PcWidth  next PC for that warp.
- dec_act_mask_i  in  WarpWidth  next active mask.
- dec_stop_i  in  1  warp finished; free it.
- busy_o  out  1  any warp not IDLE.

Behaviour:
- Per-warp state: IDLE, READY, WAITING, stored in 2 bits; plus pc and act_mask registers.
- Reset (async, rst_ni=0): all warps IDLE, pc='0, act_mask='0, rr pointer=0, lock=0.
  - Outputs during reset: fe_valid_o=0, init_ready_o=1, init_warp_id_o=0, busy_o=0; fe_* data '0.
- Init:
  - Handshake = init_valid_i & init_ready_o.
  - Warp init_warp_id_o goes IDLE→READY next cycle with pc=init_pc_i, act_mask=init_act_mask_i.
  - init_warp_id_o is a combinational lowest-index-IDLE priority encode.
  - init_ready_o=0 when no warp is IDLE.
- Arbitration:
  - Candidate = first READY warp scanning from rr pointer upward, modulo NumWarps.
  - fe_valid_o = any READY warp, or lock set.
  - fe_* outputs are combinational from the selected warp's registers; zero latency.
- Stability rule: when fe_valid_o=1 and ic_ready_i=0, set lock and hold the selected warp id.
  - fe_warp_id_o, fe_pc_o and fe_act_mask_o must not change until the handshake completes.
  - Newly READY warps do not preempt a locked selection.
- Fetch handshake (fe_valid_o & ic_ready_i):
  - Selected warp READY→WAITING.
  - rr pointer ← selected+1, wrapping NumWarps-1→0.
  - Lock clears.
- Decode feedback (dec_valid_i):
  - Applies only if warp dec_warp_id_i is WAITING; otherwise ignored with no state change.
  - dec_stop_i=1: warp → IDLE; pc and mask are retained but meaningless.
  - dec_stop_i=0: warp → READY, pc←dec_next_pc_i, act_mask←dec_act_mask_i.
  - No PC arithmetic in this block; decode supplies the full next PC, no wrap handling needed.
- Simultaneous events:
  - Init, fetch handshake and decode feedback in the same cycle all act on different warps by construction (IDLE / READY / WAITING), and all take effect.
  - A warp freed by dec_stop_i is not allocatable until the next cycle, because init_ready_o and init_warp_id_o come from registered state.
  - A warp made READY by decode is eligible for arbitration from the next cycle.
- busy_o = OR over warps of (state≠IDLE), combinational.
- Reset mid-operation clears everything immediately. Outstanding cache requests are dropped; the surrounding logic resets in the same domain.

Test Plan:
- Reset, then check outputs → fe_valid_o=0, init_ready_o=1, init_warp_id_o=0, busy_o=0.
- Init pc=0x10, mask=0xFFFF_FFFF, ic_ready_i=1 → next cycle fe_valid_o=1, fe_warp_id_o=0, fe_pc_o=0x10; after handshake fe_valid_o=0, busy_o=1.
  - Then dec_valid_i with warp 0, next_pc=0x11 → next cycle fe_pc_o=0x11.
- Init warps 0,1,2 (pcs 0x0,0x100,0x200), ic_ready_i=1, decode echoes pc+1 each cycle → grant order 0,1,2,0,1,2; each warp's pc increments by 1 per visit.
- Warps 0 and 3 READY, ic_ready_i=0 for 4 cycles, warp 1 made READY meanwhile → fe_warp_id_o=0 and fe_pc_o constant for all 4 cycles; after ic_ready_i=1 the next grant is 1, then 3.
- dec_valid_i for warp 5 while IDLE, and for warp 0 while READY → no state change, no extra fetch.
  - dec_stop_i for WAITING warp 0 → warp 0 IDLE, init_warp_id_o=0 next cycle.
- Allocate all 8 warps → init_ready_o=0 after the 8th handshake; init_valid_i held high allocates nothing.
  - Stop warp 6 → init_ready_o=1, init_warp_id_o=6.
